// File: rtl/unpacker_pkg.sv
// Shared types and default geometry for the stream unpacker.
package unpacker_pkg;

  typedef enum logic [1:0] {
    StReset,
    StIdle,
    StSend
  } state_e;

  localparam int unsigned IN_BYTES_DEF  = 160;
  localparam int unsigned OUT_BYTES_DEF = 32;

endpackage

// File: rtl/unpacker_stream.sv
// Splits wide input beats into OUT_BYTES-wide output words, lowest word first,
// tracking packet framing and flagging protocol violations.
module unpacker_stream
  import unpacker_pkg::*;
#(
  parameter int unsigned IN_BYTES  = IN_BYTES_DEF,
  parameter int unsigned OUT_BYTES = OUT_BYTES_DEF,
  parameter int unsigned VBC_W     = $clog2(IN_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   val,
  input  logic                   sop,
  input  logic                   eop,
  input  logic [VBC_W-1:0]       vbc,
  input  logic [IN_BYTES*8-1:0]  data,
  output logic                   ready,
  input  logic                   dn_ready,
  output logic                   o_val,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic [VBC_W-1:0]       o_vbc,
  output logic [OUT_BYTES*8-1:0] o_data,
  output logic                   idle,
  output logic                   err
);

  localparam int unsigned WORDS = IN_BYTES / OUT_BYTES;
  localparam int unsigned KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned OW    = OUT_BYTES * 8;
  localparam logic [VBC_W-1:0] IN_V  = VBC_W'(IN_BYTES);
  localparam logic [VBC_W-1:0] OUT_V = VBC_W'(OUT_BYTES);

  if ((IN_BYTES % OUT_BYTES) != 0 || IN_BYTES < OUT_BYTES) begin : g_bad_params
    $error("unpacker_stream: IN_BYTES must be a non-zero multiple of OUT_BYTES");
  end

  state_e               state;
  logic [KW-1:0]        k;
  logic [KW-1:0]        n_last;
  logic                 cap_eop;
  logic [VBC_W-1:0]     cap_last_vbc;
  logic [IN_BYTES*8-1:0] cap_data;
  logic                 in_pkt;

  logic                 accept;
  logic                 load;
  logic                 viol;
  logic                 last_word;
  logic [KW-1:0]        k_nxt;
  logic [VBC_W-1:0]     vbc_c;
  logic [VBC_W-1:0]     nl_full;
  logic [KW-1:0]        in_n_last;
  logic [VBC_W-1:0]     in_last_vbc;

  always_comb begin
    vbc_c       = (vbc > IN_V) ? IN_V : vbc;
    nl_full     = (vbc_c == '0) ? '0 : (vbc_c - 1'b1) / OUT_V;
    in_n_last   = KW'(nl_full);
    in_last_vbc = vbc_c - nl_full * OUT_V;
    last_word   = (k == n_last);
    k_nxt       = k + 1'b1;
    ready       = (state == StIdle) || (state == StSend && last_word && dn_ready);
    idle        = (state == StIdle);
    accept      = val && ready;
    // Zero-byte beats only touch packet tracking; they never produce a word.
    load        = accept && (vbc_c != '0);
    viol        = (vbc > IN_V) || (sop && in_pkt) || (!sop && !in_pkt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StReset;
      k            <= '0;
      n_last       <= '0;
      cap_eop      <= 1'b0;
      cap_last_vbc <= '0;
      cap_data     <= '0;
      in_pkt       <= 1'b0;
      err          <= 1'b0;
      o_val        <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_vbc        <= '0;
      o_data       <= '0;
    end else begin
      err <= accept && viol;
      if (accept) begin
        in_pkt <= eop ? 1'b0 : (sop ? 1'b1 : in_pkt);
      end

      if (load) begin
        state        <= StSend;
        k            <= '0;
        n_last       <= in_n_last;
        cap_eop      <= eop;
        cap_last_vbc <= in_last_vbc;
        cap_data     <= data;
        o_val        <= 1'b1;
        o_sop        <= sop;
        o_eop        <= eop && (in_n_last == '0);
        o_vbc        <= (in_n_last == '0) ? vbc_c : OUT_V;
        o_data       <= data[OW-1:0];
      end else begin
        unique case (state)
          StReset: state <= StIdle;
          StIdle:  state <= StIdle;
          StSend: begin
            if (dn_ready) begin
              if (!last_word) begin
                k      <= k_nxt;
                o_sop  <= 1'b0;
                o_eop  <= cap_eop && (k_nxt == n_last);
                o_vbc  <= (k_nxt == n_last) ? cap_last_vbc : OUT_V;
                o_data <= cap_data[int'(k_nxt)*OW +: OW];
              end else begin
                state <= StIdle;
                k     <= '0;
                o_val <= 1'b0;
                o_sop <= 1'b0;
                o_eop <= 1'b0;
                o_vbc <= '0;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
